// File: rtl/bus_pkg.sv
// Shared types and helpers for the CPU bus multiplexer/arbiter.
package bus_pkg;

    typedef enum logic {
        ARB_PRIO = 1'b0,
        ARB_RR   = 1'b1
    } arb_mode_e;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned sel_w(input int unsigned n);
        int unsigned w;
        w = int'($clog2(n));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_grant_pick.sv
// Combinational grant selection: fixed priority or circular search from a start pointer.
module bus_grant_pick
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned SEL_W   = sel_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   start_ptr,
    input  logic               mode,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   grant_idx,
    output logic               multi
);

    int unsigned base;
    int unsigned idx;

    // Fixed priority is the circular search started at index 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        base        = (mode == ARB_RR) ? 32'(start_ptr) : 0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = base + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (req[SEL_W'(idx)] && !grant_valid) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
        multi = ($countones(req) >= 2);
    end

endmodule

// File: rtl/bus_mux_arb.sv
// Registered CPU bus multiplexer with fixed-priority / round-robin arbitration
// and sticky, saturating contention tracking.
module bus_mux_arb
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_SRC   = 24,
    parameter bit          HOLD_LAST = 1'b1,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_out,
    input  logic                       arb_mode,
    input  logic                       err_clear,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid,
    output logic [sel_w(NUM_SRC)-1:0]  bus_src,
    output logic                       contention,
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int unsigned SEL_W = sel_w(NUM_SRC);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             multi;

    bus_grant_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req         (src_out),
        .start_ptr   (ptr_q),
        .mode        (arb_mode),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .multi       (multi)
    );

    always_comb begin
        bus_d   = bus_q;
        valid_d = grant_valid;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (grant_valid) begin
            bus_d = src_data[grant_idx*WIDTH +: WIDTH];
            src_d = grant_idx;
            if (arb_mode == ARB_RR) begin
                ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end else if (!HOLD_LAST) begin
            bus_d = '0;
        end

        // A contention event on the clearing edge takes precedence over the clear.
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (multi) begin
            flag_d = 1'b1;
            if (err_clear) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (err_clear) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            ptr_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_out        = bus_q;
    assign bus_valid      = valid_q;
    assign bus_src        = src_q;
    assign contention     = flag_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Self-checking bench for bus_mux_arb: directed test-plan steps plus random traffic
// against a queue-based reference model; a HOLD_LAST=0 copy checks idle zeroing.
module tb_bus_mux_arb;

    localparam int unsigned W = 32;
    localparam int unsigned N = 24;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_out = '0;
    logic             arb_mode = 1'b0;
    logic             err_clear = 1'b0;
    logic [W-1:0]     words [N];

    logic [W-1:0]     bus_out, bus_out0;
    logic             bus_valid, bus_valid0;
    logic [4:0]       bus_src, bus_src0;
    logic             contention, contention0;
    logic [7:0]       contention_cnt, contention_cnt0;

    int unsigned total = 0;
    int unsigned bad = 0;

    // reference model state
    logic [W-1:0] m_bus, m_bus0;
    int unsigned  m_src, m_ptr, m_cnt;
    bit           m_valid, m_flag;

    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N; i++) src_data[i*W +: W] = words[i];
    end

    bus_mux_arb #(.WIDTH(W), .NUM_SRC(N), .HOLD_LAST(1'b1), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
        .arb_mode(arb_mode), .err_clear(err_clear), .bus_out(bus_out),
        .bus_valid(bus_valid), .bus_src(bus_src), .contention(contention),
        .contention_cnt(contention_cnt)
    );

    bus_mux_arb #(.WIDTH(W), .NUM_SRC(N), .HOLD_LAST(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out),
        .arb_mode(arb_mode), .err_clear(err_clear), .bus_out(bus_out0),
        .bus_valid(bus_valid0), .bus_src(bus_src0), .contention(contention0),
        .contention_cnt(contention_cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bus = '0; m_bus0 = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
        m_valid = 0; m_flag = 0;
    endtask

    // Next state from the inputs currently applied, as seen at the coming edge.
    task automatic model_edge();
        int unsigned en[$];
        int unsigned g;
        bit found;
        for (int i = 0; i < N; i++) if (src_out[i]) en.push_back(i);
        if (en.size() > 0) begin
            g = en[0];
            if (arb_mode) begin
                found = 0;
                foreach (en[j]) if (!found && en[j] >= m_ptr) begin g = en[j]; found = 1; end
                m_ptr = (g + 1) % N;
            end
            m_bus = words[g]; m_bus0 = words[g]; m_src = g; m_valid = 1;
        end else begin
            m_valid = 0; m_bus0 = '0;
        end
        if (en.size() >= 2) begin
            m_flag = 1;
            m_cnt = err_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (err_clear) begin
            m_flag = 0; m_cnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bus"},   bus_out, m_bus);
        chk({tag, "_valid"}, bus_valid, m_valid);
        chk({tag, "_src"},   bus_src, m_src);
        chk({tag, "_flag"},  contention, m_flag);
        chk({tag, "_cnt"},   contention_cnt, m_cnt);
        chk({tag, "_bus0"},  bus_out0, m_bus0);
        chk({tag, "_valid0"}, bus_valid0, m_valid);
    endtask

    task automatic edge_chk(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < N; i++) words[i] = $urandom;
        model_reset();
        #7;
        check_all("reset");
        clr = 1'b0;
        #9;   // t=16, just after the posedge at 15 with no requests yet
        check_all("first");

        // fixed priority, two drivers
        words[3] = 32'h0000_00A3; words[7] = 32'h0000_00A7;
        arb_mode = 1'b0; src_out = '0; src_out[3] = 1'b1; src_out[7] = 1'b1;
        edge_chk("prio");
        chk("prio_bus_k", bus_out, 32'h0000_00A3);
        chk("prio_src_k", bus_src, 3);
        chk("prio_cnt_k", contention_cnt, 1);

        // clear counter, then round-robin rotation including pointer wrap
        src_out = '0; err_clear = 1'b1;
        edge_chk("clr1");
        err_clear = 1'b0; arb_mode = 1'b1;
        src_out[2] = 1'b1; src_out[5] = 1'b1; src_out[23] = 1'b1;
        edge_chk("rr0"); chk("rr0_src_k", bus_src, 2);
        edge_chk("rr1"); chk("rr1_src_k", bus_src, 5);
        edge_chk("rr2"); chk("rr2_src_k", bus_src, 23);
        edge_chk("rr3"); chk("rr3_src_k", bus_src, 2);
        chk("rr_cnt_k", contention_cnt, 4);

        // hold and idle
        arb_mode = 1'b0; src_out = '0; src_out[0] = 1'b1; words[0] = 32'hDEAD_BEEF;
        edge_chk("hold_g");
        src_out = '0;
        for (int i = 0; i < 3; i++) edge_chk("idle");
        chk("idle_bus_k", bus_out, 32'hDEAD_BEEF);
        chk("idle_bus0_k", bus_out0, 0);
        chk("idle_valid_k", bus_valid, 0);

        // saturation over 300 contended edges
        for (int i = 0; i < 300; i++) begin
            arb_mode = 1'($urandom_range(0, 1));
            src_out = N'($urandom) | N'(1 << $urandom_range(0, 11)) | N'(1 << $urandom_range(12, 23));
            words[$urandom_range(0, N - 1)] = $urandom;
            edge_chk("sat");
        end
        chk("sat_cnt_k", contention_cnt, 255);
        err_clear = 1'b1; src_out = 24'h000011;
        edge_chk("clr_cont");
        chk("clr_cont_k", contention_cnt, 1);
        src_out = 24'h000100;
        edge_chk("clr_only");
        chk("clr_only_cnt_k", contention_cnt, 0);
        chk("clr_only_flag_k", contention, 0);
        err_clear = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            arb_mode = 1'($urandom_range(0, 1));
            err_clear = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: src_out = '0;
                1: src_out = N'(1 << $urandom_range(0, N - 1));
                2: src_out = N'($urandom) & N'($urandom) & N'($urandom);
                default: src_out = N'($urandom);
            endcase
            words[$urandom_range(0, N - 1)] = $urandom;
            edge_chk("rnd");
        end
        err_clear = 1'b0;

        // reset mid-operation with rr_ptr = 5
        arb_mode = 1'b1; src_out = '0; src_out[4] = 1'b1;
        edge_chk("pre_rst");
        chk("pre_rst_valid_k", bus_valid, 1);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        #1;
        clr = 1'b0;
        src_out = '1;
        edge_chk("post_rst");
        chk("post_rst_src_k", bus_src, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
